// File: rtl/cordic_mul_arbiter.sv
// cordic_mul_arbiter
//   Round-robin scheduler that shares one iterative CORDIC multiplier among
//   NUM_REQ requesters. It takes one request at a time, latches its operands,
//   pulses the multiplier start and waits for done. It then returns the
//   product to the owning requester. A watchdog aborts a multiplication that
//   never finishes and returns an error response with a zero product.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (ready is one-hot or zero)
//   req_x, req_z          packed signed operands, slice i belongs to requester i
//   rsp_valid/rsp_ready   response handshake
//   rsp_id, rsp_y, rsp_err owner index, product, timeout flag (product 0 on timeout)
//   mul_start             one-cycle start pulse to the multiplier
//   mul_x, mul_z          operands, stable from launch until the response is taken
//   mul_y, mul_done       multiplier result and level done flag
//   busy                  high whenever an operation is in progress
module cordic_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int PROD_W  = 16,
  parameter int MIN_LAT = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_x,
  input  logic [NUM_REQ*DATA_W-1:0]   req_z,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [PROD_W-1:0]           rsp_y,
  output logic                        rsp_err,
  output logic                        mul_start,
  output logic [DATA_W-1:0]           mul_x,
  output logic [DATA_W-1:0]           mul_z,
  input  logic [PROD_W-1:0]           mul_y,
  input  logic                        mul_done,
  output logic                        busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MIN_LAT_C = CNT_W'(MIN_LAT);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   mul_x_q, mul_x_d;
  logic [DATA_W-1:0]   mul_z_q, mul_z_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [PROD_W-1:0]   rsp_y_q, rsp_y_d;
  logic                rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_next;

  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     cand;

  // Modular add that also works when NUM_REQ is not a power of two.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap_add(rr_ptr_q, k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Ready is gated with rst_n so it reads zero while reset is held, even
  // though the state register already sits in IDLE.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_found && rst_n) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    mul_x_d   = mul_x_q;
    mul_z_d   = mul_z_q;
    rsp_id_d  = rsp_id_q;
    rsp_y_d   = rsp_y_q;
    rsp_err_d = rsp_err_q;
    cnt_d     = cnt_q;
    cnt_next  = cnt_q + CNT_W'(1);
    mul_start = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          for (int k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == grant_idx) begin
              mul_x_d = req_x[k*DATA_W +: DATA_W];
              mul_z_d = req_z[k*DATA_W +: DATA_W];
            end
          end
          rsp_id_d = grant_idx;
          rr_ptr_d = wrap_add(grant_idx, 1);
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        mul_start = 1'b1;
        cnt_d     = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // cnt_next is the 1-based index of the current WAIT cycle. A done
        // seen in the first MIN_LAT cycles may be left over from the
        // previous operation, so it is ignored. A real done beats the
        // timeout when both occur in the same cycle.
        cnt_d = cnt_next;
        if (cnt_next > MIN_LAT_C && mul_done) begin
          rsp_y_d   = mul_y;
          rsp_err_d = 1'b0;
          state_d   = S_RESP;
        end else if (cnt_next == TIMEOUT_C) begin
          rsp_y_d   = '0;
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      mul_x_q   <= '0;
      mul_z_q   <= '0;
      rsp_id_q  <= '0;
      rsp_y_q   <= '0;
      rsp_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      mul_x_q   <= mul_x_d;
      mul_z_q   <= mul_z_d;
      rsp_id_q  <= rsp_id_d;
      rsp_y_q   <= rsp_y_d;
      rsp_err_q <= rsp_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_err   = rsp_err_q;
  assign mul_x     = mul_x_q;
  assign mul_z     = mul_z_q;

endmodule

// File: tb/tb_cordic_mul_arbiter.sv
// tb_cordic_mul_arbiter
//   Self-checking bench for cordic_mul_arbiter. A behavioural multiplier
//   model with configurable latency, hang and stale-done behaviour sits on
//   the multiplier port. Expected grant order, product, error flag and
//   latency come from plain arithmetic on the block's scheduling rules.
module tb_cordic_mul_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int PROD_W  = 16;
  localparam int MIN_LAT = 2;
  localparam int TIMEOUT = 64;
  localparam int LIMIT   = 200;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NUM_REQ-1:0]         req_valid = '0;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*DATA_W-1:0]  req_x = '0;
  logic [NUM_REQ*DATA_W-1:0]  req_z = '0;
  logic                       rsp_valid;
  logic                       rsp_ready = 1'b1;
  logic [1:0]                 rsp_id;
  logic [PROD_W-1:0]          rsp_y;
  logic                       rsp_err;
  logic                       mul_start;
  logic [DATA_W-1:0]          mul_x, mul_z;
  logic [PROD_W-1:0]          mul_y = '0;
  logic                       mul_done = 1'b0;
  logic                       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int ref_ptr  = 0;

  // multiplier model controls
  int  m_lat   = 3;
  bit  m_hang  = 1'b0;
  bit  m_stale = 1'b0;
  int  m_k     = 0;
  bit  m_active = 1'b0;
  logic [PROD_W-1:0] m_prod;
  logic signed [15:0] m_sx, m_sz;

  always #5 clk = ~clk;

  cordic_mul_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .PROD_W(PROD_W),
    .MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_z(req_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_x(mul_x), .mul_z(mul_z),
    .mul_y(mul_y), .mul_done(mul_done), .busy(busy)
  );

  // Multiplier model, updated on the falling edge. k counts falling edges
  // since the start pulse; the value set at edge k is what the DUT sees at
  // the end of WAIT cycle k.
  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        mul_done = 1'b0;
        mul_y    = '0;
        m_active = 1'b0;
      end else if (mul_start) begin
        m_active = 1'b1;
        m_k      = 0;
        m_sx     = {{8{mul_x[7]}}, mul_x};
        m_sz     = {{8{mul_z[7]}}, mul_z};
        m_prod   = m_sx * m_sz;
        if (!m_stale) mul_done = 1'b0;
      end else if (m_active) begin
        m_k++;
        mul_done = (m_stale && m_k <= MIN_LAT) || (!m_hang && m_k >= m_lat);
        if (!m_hang && m_k >= m_lat) mul_y = m_prod;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation time limit reached");
    $fatal(1, "[TB] bench stalled");
  end

  function automatic int next_grant(input logic [3:0] v);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(ref_ptr + k) % NUM_REQ]) return (ref_ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = $signed(a) * $signed(b);
    return p[15:0];
  endfunction

  // Cycles from the grant cycle to the first rsp_valid cycle.
  function automatic int ref_latency(input int lat, input bit hang);
    int w;
    if (hang) w = TIMEOUT;
    else begin
      w = (lat > MIN_LAT + 1) ? lat : MIN_LAT + 1;
      if (w > TIMEOUT) w = TIMEOUT;
    end
    return w + 2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] x, input logic [7:0] z);
    req_x[i*DATA_W +: DATA_W] = x;
    req_z[i*DATA_W +: DATA_W] = z;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ref_ptr = 0;
    step();
  endtask

  // Waits for a grant; returns at the drive point of the LAUNCH cycle.
  task automatic get_grant(output logic [3:0] rdy, output int waited, output bit to);
    waited = 0;
    #1;
    rdy = req_ready;
    while (rdy == '0 && waited < LIMIT) begin
      step(); #1;
      rdy = req_ready;
      waited++;
    end
    to = (rdy == '0);
    step();
  endtask

  // Called at the LAUNCH drive point; returns at the sample point of the
  // first rsp_valid cycle.
  task automatic get_rsp(output int cycles, output int starts, output int leaks, output bit to);
    cycles = 1; starts = 0; leaks = 0;
    #1;
    while (!rsp_valid && cycles < LIMIT) begin
      if (mul_start) starts++;
      if (req_ready != '0) leaks++;
      step(); #1;
      cycles++;
    end
    to = !rsp_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'hF;
    req_x = $urandom; req_z = $urandom;
    step(); #1;
    n_checks++;
    if (req_ready !== 4'b0) $display("[TB] FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
    n_checks++;
    if ({rsp_valid, busy, mul_start} !== 3'b0) $display("[TB] FAIL reset_ctrl: got %b want 000", {rsp_valid, busy, mul_start}); else n_pass++;
    n_checks++;
    if ({mul_x, mul_z} !== 16'h0) $display("[TB] FAIL reset_operands: got %h want 0000", {mul_x, mul_z}); else n_pass++;
    n_checks++;
    if ({rsp_id, rsp_y, rsp_err} !== 19'h0) $display("[TB] FAIL reset_rsp: got %h want 0", {rsp_id, rsp_y, rsp_err}); else n_pass++;
    req_valid = '0;
    step();
    rst_n = 1'b1;
    ref_ptr = 0;
    step();
  endtask

  task automatic test_single();
    logic [3:0] rdy; int waited, cyc, st, lk; bit to;
    m_lat = 3; m_hang = 0; m_stale = 0;
    set_req(0, 8'd12, 8'hF9);
    req_valid = 4'b0001;
    get_grant(rdy, waited, to);
    ref_ptr = 1;
    req_valid = '0;
    n_checks++;
    if (rdy !== 4'b0001 || to) $display("[TB] FAIL single_grant: got %b want 0001", rdy); else n_pass++;
    get_rsp(cyc, st, lk, to);
    n_checks++;
    if (to || cyc != ref_latency(3, 0)) $display("[TB] FAIL single_latency: got %0d want %0d", cyc, ref_latency(3, 0)); else n_pass++;
    n_checks++;
    if (st != 1) $display("[TB] FAIL single_starts: got %0d want 1", st); else n_pass++;
    n_checks++;
    if ({rsp_id, rsp_y, rsp_err} !== {2'd0, 16'hFFAC, 1'b0})
      $display("[TB] FAIL single_rsp: got id=%0d y=%h err=%b want id=0 y=ffac err=0", rsp_id, rsp_y, rsp_err);
    else n_pass++;
    step();
  endtask

  task automatic test_round_robin();
    logic [3:0] rdy; int waited, cyc, st, lk, exp; bit to;
    logic [7:0] ax[4], az[4];
    pulse_reset();
    m_lat = 1; m_hang = 0; m_stale = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ax[i] = 8'($urandom); az[i] = 8'($urandom);
      set_req(i, ax[i], az[i]);
    end
    req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      exp = next_grant(req_valid);
      get_grant(rdy, waited, to);
      ref_ptr = (exp + 1) % NUM_REQ;
      n_checks++;
      if (to || rdy !== 4'(1 << exp)) $display("[TB] FAIL rr_grant_%0d: got %b want %b", n, rdy, 4'(1 << exp)); else n_pass++;
      get_rsp(cyc, st, lk, to);
      n_checks++;
      if (to || lk != 0 || cyc != ref_latency(1, 0))
        $display("[TB] FAIL rr_timing_%0d: got lat=%0d leaks=%0d want lat=%0d leaks=0", n, cyc, lk, ref_latency(1, 0));
      else n_pass++;
      n_checks++;
      if ({rsp_id, rsp_y, rsp_err} !== {2'(exp), ref_prod(ax[exp], az[exp]), 1'b0})
        $display("[TB] FAIL rr_rsp_%0d: got id=%0d y=%h err=%b want id=%0d y=%h err=0", n, rsp_id, rsp_y, rsp_err, exp, ref_prod(ax[exp], az[exp]));
      else n_pass++;
      step();
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_timeout();
    logic [3:0] rdy; int waited, cyc, st, lk; bit to;
    m_hang = 1; m_stale = 0;
    set_req(2, 8'd5, 8'd9);
    req_valid = 4'b0100;
    get_grant(rdy, waited, to);
    ref_ptr = 3;
    req_valid = '0;
    get_rsp(cyc, st, lk, to);
    n_checks++;
    if (to || cyc != TIMEOUT + 2) $display("[TB] FAIL timeout_latency: got %0d want %0d", cyc, TIMEOUT + 2); else n_pass++;
    n_checks++;
    if ({rsp_id, rsp_y, rsp_err} !== {2'd2, 16'h0, 1'b1})
      $display("[TB] FAIL timeout_rsp: got id=%0d y=%h err=%b want id=2 y=0000 err=1", rsp_id, rsp_y, rsp_err);
    else n_pass++;
    step();
    m_hang = 0; m_lat = 2;
    set_req(3, 8'h80, 8'h7F);
    req_valid = 4'b1000;
    get_grant(rdy, waited, to);
    ref_ptr = 0;
    req_valid = '0;
    get_rsp(cyc, st, lk, to);
    n_checks++;
    if (to || {rsp_id, rsp_y, rsp_err} !== {2'd3, ref_prod(8'h80, 8'h7F), 1'b0})
      $display("[TB] FAIL after_timeout_rsp: got id=%0d y=%h err=%b want id=3 y=%h err=0", rsp_id, rsp_y, rsp_err, ref_prod(8'h80, 8'h7F));
    else n_pass++;
    step();
  endtask

  task automatic test_stale_done();
    logic [3:0] rdy; int waited, cyc, st, lk; bit to;
    m_stale = 1; m_hang = 0; m_lat = 5;
    set_req(1, 8'hF0, 8'd3);
    req_valid = 4'b0010;
    get_grant(rdy, waited, to);
    ref_ptr = 2;
    req_valid = '0;
    get_rsp(cyc, st, lk, to);
    n_checks++;
    if (to || cyc != ref_latency(5, 0)) $display("[TB] FAIL stale_latency: got %0d want %0d", cyc, ref_latency(5, 0)); else n_pass++;
    n_checks++;
    if ({rsp_y, rsp_err} !== {ref_prod(8'hF0, 8'd3), 1'b0})
      $display("[TB] FAIL stale_rsp: got y=%h err=%b want y=%h err=0", rsp_y, rsp_err, ref_prod(8'hF0, 8'd3));
    else n_pass++;
    m_stale = 0;
    step();
  endtask

  task automatic test_back_to_back_backpressure();
    logic [3:0] rdy; int waited, cyc, st, lk, bad, exp; bit to;
    m_lat = 2; m_hang = 0; m_stale = 0;
    rsp_ready = 1'b0;
    set_req(0, 8'd100, 8'hCE);
    set_req(1, 8'h9C, 8'h9C);
    req_valid = 4'b0001;
    exp = next_grant(req_valid);
    get_grant(rdy, waited, to);
    ref_ptr = (exp + 1) % NUM_REQ;
    n_checks++;
    if (to || rdy !== 4'(1 << exp)) $display("[TB] FAIL bp_grant0: got %b want %b", rdy, 4'(1 << exp)); else n_pass++;
    req_valid = 4'b0010;
    get_rsp(cyc, st, lk, to);
    bad = to ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      step(); #1;
      if (!rsp_valid || rsp_id !== 2'd0 || rsp_y !== ref_prod(8'd100, 8'hCE) || rsp_err !== 1'b0 ||
          req_ready !== 4'b0 || mul_x !== 8'd100) bad++;
    end
    step();
    rsp_ready = 1'b1;
    #1;
    if (req_ready !== 4'b0) bad++;
    n_checks++;
    if (bad != 0) $display("[TB] FAIL bp_hold: got %0d unstable cycles want 0", bad); else n_pass++;
    step();
    exp = next_grant(req_valid);
    get_grant(rdy, waited, to);
    ref_ptr = (exp + 1) % NUM_REQ;
    req_valid = '0;
    n_checks++;
    if (to || rdy !== 4'b0010 || waited != 0)
      $display("[TB] FAIL bp_next_grant: got %b after %0d cycles want 0010 after 0", rdy, waited);
    else n_pass++;
    get_rsp(cyc, st, lk, to);
    n_checks++;
    if (to || {rsp_id, rsp_y} !== {2'd1, ref_prod(8'h9C, 8'h9C)})
      $display("[TB] FAIL bp_rsp1: got id=%0d y=%h want id=1 y=%h", rsp_id, rsp_y, ref_prod(8'h9C, 8'h9C));
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    logic [3:0] rdy; int waited, bad; bit to;
    m_lat = 10; m_hang = 0; m_stale = 0;
    set_req(2, 8'd7, 8'd7);
    req_valid = 4'b0100;
    get_grant(rdy, waited, to);
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, rsp_valid, mul_start, req_ready, mul_x, mul_z, rsp_y, rsp_err, rsp_id} !== '0)
      $display("[TB] FAIL midreset_outputs: got busy=%b rv=%b st=%b rdy=%b x=%h y=%h err=%b",
               busy, rsp_valid, mul_start, req_ready, mul_x, rsp_y, rsp_err);
    else n_pass++;
    req_valid = '0;
    step();
    rst_n = 1'b1;
    ref_ptr = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(); #1;
      if (rsp_valid || busy) bad++;
    end
    n_checks++;
    if (bad != 0) $display("[TB] FAIL midreset_no_rsp: got %0d active cycles want 0", bad); else n_pass++;
    step();
  endtask

  task automatic test_random();
    logic [3:0] rdy, v; int waited, cyc, st, lk, exp, lat, d; bit to, hang;
    logic [7:0] ax[4], az[4];
    logic [15:0] ey;
    for (int n = 0; n < 24; n++) begin
      v = 4'($urandom_range(1, 15));
      lat = $urandom_range(1, 8);
      hang = ($urandom_range(0, 7) == 0);
      d = $urandom_range(0, 3);
      m_lat = lat; m_hang = hang; m_stale = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        ax[i] = 8'($urandom); az[i] = 8'($urandom);
        set_req(i, ax[i], az[i]);
      end
      rsp_ready = (d == 0);
      req_valid = v;
      exp = next_grant(v);
      get_grant(rdy, waited, to);
      ref_ptr = (exp + 1) % NUM_REQ;
      req_valid = '0;
      n_checks++;
      if (to || rdy !== 4'(1 << exp)) $display("[TB] FAIL rand_grant_%0d: got %b want %b", n, rdy, 4'(1 << exp)); else n_pass++;
      get_rsp(cyc, st, lk, to);
      ey = hang ? 16'h0 : ref_prod(ax[exp], az[exp]);
      n_checks++;
      if (to || cyc != ref_latency(lat, hang) || {rsp_id, rsp_y, rsp_err} !== {2'(exp), ey, hang})
        $display("[TB] FAIL rand_rsp_%0d: got lat=%0d id=%0d y=%h err=%b want lat=%0d id=%0d y=%h err=%b",
                 n, cyc, rsp_id, rsp_y, rsp_err, ref_latency(lat, hang), exp, ey, hang);
      else n_pass++;
      for (int i = 0; i < d; i++) step();
      rsp_ready = 1'b1;
      step();
    end
  endtask

  initial begin
    $display("[TB] starting cordic_mul_arbiter bench");
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_stale_done();
    test_back_to_back_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
